pg_header_ctrl: RTL and testbench

PG_HEADER_CTRL -- requirements
Module: pg_header_ctrl

---
 rtl/pg_header_ctrl.sv | 146 ++++++++++++++
 tb/tb_pg_header_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pg_header_ctrl.sv
// Power-gating header controller: staged PMOS ramp-up/down with isolation.
// Optional retention handshake outputs are built when PG_RETENTION_EN is defined.
module pg_header_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_DLY  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwr_req,
    output logic [NUM_STAGES-1:0] pmos_gate,
    output logic                  iso_en,
    output logic                  pwr_ack,
`ifdef PG_RETENTION_EN
    output logic                  ret_save,
    output logic                  ret_restore,
`endif
    output logic                  busy
);

    localparam int SW = $clog2(NUM_STAGES + 1);
    localparam logic [7:0]    DLY_RLD = 8'(STAGE_DLY - 1);
    localparam logic [SW-1:0] STG_MAX = SW'(NUM_STAGES);
    localparam logic [SW-1:0] STG_ONE = SW'(1);

    typedef enum logic [1:0] {
        OFF,
        RAMP_UP,
        ON,
        RAMP_DOWN
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           stg_q, stg_d;
    logic [7:0]              dly_q, dly_d;
    logic [NUM_STAGES-1:0]   gate_q, gate_d;
    logic                    iso_q, iso_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
`ifdef PG_RETENTION_EN
    logic                    save_q, save_d;
    logic                    rest_q, rest_d;
`endif

    // stg counts enabled segments; dly counts down to the next segment step
    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        dly_d   = (dly_q != 8'd0) ? dly_q - 8'd1 : dly_q;
        unique case (state_q)
            OFF: begin
                if (pwr_req) begin
                    state_d = RAMP_UP;
                    stg_d   = STG_ONE;
                    dly_d   = DLY_RLD;
                end
            end
            RAMP_UP: begin
                if (!pwr_req) begin
                    state_d = RAMP_DOWN;
                    dly_d   = DLY_RLD;
                end else if (dly_q == 8'd0) begin
                    if (stg_q == STG_MAX) begin
                        state_d = ON;
                        dly_d   = 8'd0;
                    end else begin
                        stg_d = stg_q + STG_ONE;
                        dly_d = DLY_RLD;
                    end
                end
            end
            ON: begin
                if (!pwr_req) begin
                    state_d = RAMP_DOWN;
                    dly_d   = DLY_RLD;
                end
            end
            RAMP_DOWN: begin
                if (dly_q == 8'd0) begin
                    stg_d = stg_q - STG_ONE;
                    if (stg_q == STG_ONE) begin
                        state_d = OFF;
                        dly_d   = 8'd0;
                    end else begin
                        dly_d = DLY_RLD;
                    end
                end
            end
            default: begin
                state_d = OFF;
                stg_d   = '0;
                dly_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            gate_d[k] = (SW'(k) >= stg_d);
        end
        iso_d  = (state_d != ON);
        ack_d  = (state_d == ON);
        busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
`ifdef PG_RETENTION_EN
        save_d = (state_q == ON) && (state_d == RAMP_DOWN);
        rest_d = (state_q != ON) && (state_d == ON);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            stg_q   <= '0;
            dly_q   <= 8'd0;
            gate_q  <= '1;
            iso_q   <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PG_RETENTION_EN
            save_q  <= 1'b0;
            rest_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            dly_q   <= dly_d;
            gate_q  <= gate_d;
            iso_q   <= iso_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef PG_RETENTION_EN
            save_q  <= save_d;
            rest_q  <= rest_d;
`endif
        end
    end

    assign pmos_gate = gate_q;
    assign iso_en    = iso_q;
    assign pwr_ack   = ack_q;
    assign busy      = busy_q;
`ifdef PG_RETENTION_EN
    assign ret_save    = save_q;
    assign ret_restore = rest_q;
`endif

endmodule

// File: tb/tb_pg_header_ctrl.sv
// Scoreboard bench for pg_header_ctrl against a time-arithmetic reference model.
// Retention outputs are checked when PG_RETENTION_EN is defined.
module tb_pg_header_ctrl;

    localparam int NS  = 4;
    localparam int DLY = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwr_req = 1'b0;
    logic [NS-1:0] pmos_gate;
    logic          iso_en, pwr_ack, busy;
`ifdef PG_RETENTION_EN
    logic          ret_save, ret_restore;
`endif

    always #5 clk = ~clk;

    pg_header_ctrl #(.NUM_STAGES(NS), .STAGE_DLY(DLY)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pwr_req(pwr_req),
        .pmos_gate(pmos_gate),
        .iso_en(iso_en),
        .pwr_ack(pwr_ack),
`ifdef PG_RETENTION_EN
        .ret_save(ret_save),
        .ret_restore(ret_restore),
`endif
        .busy(busy)
    );

    typedef struct {
        int            cyc;
        logic [NS-1:0] gate;
        logic          iso;
        logic          ack;
        logic          bsy;
        logic          save;
        logic          rest;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   cyc_now = 0;

    // model: mode 0=OFF 1=UP 2=ON 3=DOWN, entered at edge mt0
    int   mmode = 0;
    int   mt0 = 0;
    int   mn0 = 0;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      nm, act, exp, cyc_now);
    endtask

    function automatic int nseg(input int m);
        case (mmode)
            1: nseg = 1 + (m - mt0) / DLY;
            2: nseg = NS;
            3: nseg = mn0 - (m - mt0) / DLY;
            default: nseg = 0;
        endcase
    endfunction

    function automatic logic [NS-1:0] gate_of(input int n);
        logic [NS-1:0] g;
        g = '1;
        for (int i = 0; i < n; i++) g[i] = 1'b0;
        return g;
    endfunction

    task automatic step(input bit p);
        int   m;
        int   om;
        exp_t e;
        m  = cyc_now;
        om = mmode;
        pwr_req = p;
        case (mmode)
            0: if (p) begin mmode = 1; mt0 = m + 1; end
            1: begin
                if (!p) begin
                    mn0 = 1 + (m - mt0) / DLY;
                    mmode = 3;
                    mt0 = m + 1;
                end else if (m + 1 - mt0 == NS * DLY) begin
                    mmode = 2;
                end
            end
            2: if (!p) begin mmode = 3; mt0 = m + 1; mn0 = NS; end
            3: if (m + 1 - mt0 == mn0 * DLY) mmode = 0;
            default: mmode = 0;
        endcase
        e.cyc  = m + 1;
        e.gate = gate_of(nseg(m + 1));
        e.iso  = (mmode != 2);
        e.ack  = (mmode == 2);
        e.bsy  = (mmode == 1) || (mmode == 3);
        e.save = (om == 2) && (mmode == 3);
        e.rest = (om != 2) && (mmode == 2);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gate"}, 32'(pmos_gate), 32'hF);
        chk({tag, "_iso"}, 32'(iso_en), 32'd1);
        chk({tag, "_ack"}, 32'(pwr_ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef PG_RETENTION_EN
        chk({tag, "_save"}, 32'(ret_save), 32'd0);
        chk({tag, "_rest"}, 32'(ret_restore), 32'd0);
`endif
    endtask

    // reset between clock edges, after the pending expectation is consumed
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        pwr_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mmode = 0;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc <= cyc_now) begin
            mon_e = sbq.pop_front();
            chk("cycle", 32'(cyc_now), 32'(mon_e.cyc));
            chk("pmos_gate", 32'(pmos_gate), 32'(mon_e.gate));
            chk("iso_en", 32'(iso_en), 32'(mon_e.iso));
            chk("pwr_ack", 32'(pwr_ack), 32'(mon_e.ack));
            chk("busy", 32'(busy), 32'(mon_e.bsy));
`ifdef PG_RETENTION_EN
            chk("ret_save", 32'(ret_save), 32'(mon_e.save));
            chk("ret_restore", 32'(ret_restore), 32'(mon_e.rest));
`endif
        end
    end

    initial begin
        int len;
        bit p;
        rst_n = 1'b0;
        pwr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("init_rst");
        rst_n = 1'b1;
        mmode = 0;
        repeat (4) step(0);
        // full power-up, power-down with an early re-request
        repeat (40) step(1);
        repeat (3) step(0);
        repeat (40) step(1);
        // abort at 12 cycles into a ramp-up
        repeat (45) step(0);
        repeat (12) step(1);
        repeat (30) step(0);
        // reset mid ramp-up, then recover
        repeat (20) step(1);
        do_reset();
        repeat (40) step(1);
        repeat (40) step(0);
        for (int s = 0; s < 60; s++) begin
            p   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 50);
            repeat (len) step(p);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
